// File: rtl/pipe_register.sv
// pipe_register: DEPTH-stage valid/ready pipeline with bubble collapse,
// flush and occupancy count. Optional input skid buffer selected with the
// macro PIPE_REGISTER_SKID_EN. When it is defined, in_ready comes from a
// flop and has no combinational path from out_ready. Without it, in_ready
// is combinational through the stage chain.
module pipe_register #(
  parameter int FIXED_POINT = 16,
  parameter int DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FIXED_POINT-1:0]         in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [FIXED_POINT-1:0]         out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           flush,
  output logic [$clog2(DEPTH+2)-1:0]     occupancy
);

  localparam int OW = $clog2(DEPTH+2);

  logic [DEPTH-1:0]                  valid_q, valid_d;
  logic [DEPTH-1:0][FIXED_POINT-1:0] data_q, data_d;
  logic [DEPTH-1:0]                  move_s;
  logic [OW-1:0]                     occ_q, occ_d;
  logic                              accept_s;
  logic                              deliver_s;
  logic                              free0_s;
  logic                              src_valid_s;
  logic [FIXED_POINT-1:0]            src_data_s;

  // A stage's word leaves when the stage ahead is empty or leaving too;
  // resolved from the output end backwards so bubbles collapse.
  always_comb begin
    logic [DEPTH-1:0] mv;
    mv = {DEPTH{1'b0}};
    mv[DEPTH-1] = valid_q[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      mv[i] = valid_q[i] & (~valid_q[i+1] | mv[i+1]);
    end
    move_s = mv;
  end

  assign free0_s   = ~valid_q[0] | move_s[0];
  assign deliver_s = move_s[DEPTH-1];

`ifdef PIPE_REGISTER_SKID_EN
  logic                   skid_valid_q, skid_valid_d;
  logic [FIXED_POINT-1:0] skid_data_q, skid_data_d;
  logic                   in_ready_q, in_ready_d;

  assign in_ready    = in_ready_q & ~flush;
  assign accept_s    = in_valid & in_ready;
  assign src_valid_s = skid_valid_q | accept_s;
  assign src_data_s  = skid_valid_q ? skid_data_q : in_data;

  // The skid entry catches an accepted word that stage 0 cannot take yet.
  // It drains into stage 0 as soon as stage 0 frees up.
  always_comb begin
    skid_valid_d = 1'b0;
    skid_data_d  = skid_data_q;
    if (flush) begin
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      skid_valid_d = ~free0_s;
    end else begin
      skid_valid_d = accept_s & ~free0_s;
      skid_data_d  = (accept_s & ~free0_s) ? in_data : skid_data_q;
    end
    in_ready_d = ~skid_valid_d;
  end

  // Skid entry and registered ready; reset leaves the input open.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= {FIXED_POINT{1'b0}};
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready    = free0_s & ~flush;
  assign accept_s    = in_valid & in_ready;
  assign src_valid_s = accept_s;
  assign src_data_s  = in_data;
`endif

  // Next stage contents: load from behind when the predecessor moves,
  // empty out when our word moves on, otherwise hold; flush drops all.
  always_comb begin
    valid_d    = {DEPTH{1'b0}};
    data_d     = data_q;
    valid_d[0] = ~flush & ((src_valid_s & free0_s) | (valid_q[0] & ~move_s[0]));
    data_d[0]  = (src_valid_s & free0_s) ? src_data_s : data_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = ~flush & (move_s[i-1] | (valid_q[i] & ~move_s[i]));
      data_d[i]  = move_s[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  // Word count tracks accepts minus deliveries; flush empties everything.
  always_comb begin
    occ_d = flush ? {OW{1'b0}} : (occ_q + OW'(accept_s) - OW'(deliver_s));
  end

  // Stage chain and occupancy registers; reset also zeroes the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {DEPTH{1'b0}};
      data_q  <= {(DEPTH*FIXED_POINT){1'b0}};
      occ_q   <= {OW{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_register.sv
// Self-checking bench for pipe_register (FIXED_POINT=16, DEPTH=4).
// A scoreboard queue receives every accepted word; deliveries pop it.
module tb_pipe_register;

  localparam int W = 16;
  localparam int D = 4;
`ifdef PIPE_REGISTER_SKID_EN
  localparam int MAXOCC = D + 1;
`else
  localparam int MAXOCC = D;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
  logic [2:0]   occupancy;

  logic [W-1:0] sb[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  pipe_register #(.FIXED_POINT(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, sample handshake, update the scoreboard.
  task automatic tick(input logic iv, input logic [W-1:0] id, input logic ordy,
                      input logic fl, input logic r,
                      output logic acc, output logic dlv, output logic [W-1:0] got,
                      output logic [W-1:0] exp, output logic under,
                      output logic ov, output logic ir);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl; rst = r;
    #1;
    ir = in_ready; ov = out_valid; got = out_data;
    acc = iv & ir & ~fl & ~r;
    dlv = ov & ordy & ~r;
    under = 1'b0; exp = 16'h0000;
    if (acc) sb.push_back(id);
    if (dlv) begin
      if (sb.size() == 0) under = 1'b1;
      else exp = sb.pop_front();
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic acc, dlv, under, ov, ir; logic [W-1:0] got, exp;
    tick(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, acc, dlv, got, exp, under, ov, ir);
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, acc, dlv, got, exp, under, ov, ir);
    sb.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream();
    logic acc, dlv, under, ov, ir; logic [W-1:0] got, exp;
    int n_sent = 0, n_dlv = 0, first_acc = -1, first_ov = -1, first_dlv = -1, last_dlv = -1, c;
    for (int t = 0; t < 40 && n_dlv < 8; t++) begin
      c = cyc;
      tick(n_sent < 8, 16'(n_sent + 1), 1'b1, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
      if (acc) begin n_sent++; if (first_acc < 0) first_acc = c; end
      if (ov && first_ov < 0) first_ov = c;
      if (dlv) begin
        n_dlv++;
        if (first_dlv < 0) first_dlv = c;
        last_dlv = c;
        n_cmp++; if (under || got !== exp || got !== 16'(n_dlv)) begin n_fail++; $display("FAIL stream_data: got %h expected %h", got, 16'(n_dlv)); end
      end
    end
    n_cmp++; if (n_dlv != 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", n_dlv); end
    n_cmp++; if (first_ov - first_acc != 4) begin n_fail++; $display("FAIL stream_latency: got %0d expected 4", first_ov - first_acc); end
    n_cmp++; if (last_dlv - first_dlv != 7) begin n_fail++; $display("FAIL stream_throughput: got span %0d expected 7", last_dlv - first_dlv); end
  endtask

  task automatic test_backpressure();
    logic acc, dlv, under, ov, ir; logic [W-1:0] got, exp;
    int n_held, n_dlv = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
    end
    n_cmp++; if (int'(occupancy) != MAXOCC) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected %0d", occupancy, MAXOCC); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    n_held = sb.size();
    n_cmp++; if (n_held != MAXOCC) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", n_held, MAXOCC); end
    for (int t = 0; t < 20 && sb.size() > 0; t++) begin
      tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
      if (dlv) begin
        n_cmp++; if (under || got !== exp || got !== 16'h0100 + 16'(n_dlv)) begin n_fail++; $display("FAIL bp_order: got %h expected %h", got, 16'h0100 + 16'(n_dlv)); end
        n_dlv++;
      end
    end
    n_cmp++; if (n_dlv != MAXOCC) begin n_fail++; $display("FAIL bp_drain: got %0d expected %0d", n_dlv, MAXOCC); end
  endtask

  task automatic test_bubble();
    logic acc, dlv, under, ov, ir; logic [W-1:0] got, exp;
    int n_dlv = 0;
    tick(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
    tick(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
    for (int t = 0; t < 4; t++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
    n_cmp++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL bubble_occupancy: got %0d expected 2", occupancy); end
    n_cmp++; if (dut.valid_q !== 4'b1100) begin n_fail++; $display("FAIL bubble_packed: got %b expected 1100", dut.valid_q); end
    n_cmp++; if (dut.data_q[3] !== 16'h00AA || dut.data_q[2] !== 16'h00BB) begin n_fail++; $display("FAIL bubble_stage_data: got %h,%h expected 00aa,00bb", dut.data_q[3], dut.data_q[2]); end
    for (int t = 0; t < 10 && sb.size() > 0; t++) begin
      tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
      if (dlv) begin
        n_cmp++; if (under || got !== exp || got !== (n_dlv == 0 ? 16'h00AA : 16'h00BB)) begin n_fail++; $display("FAIL bubble_order: got %h expected %h", got, exp); end
        n_dlv++;
      end
    end
    n_cmp++; if (n_dlv != 2) begin n_fail++; $display("FAIL bubble_drain: got %0d expected 2", n_dlv); end
  endtask

  task automatic test_flush();
    logic acc, dlv, under, ov, ir; logic [W-1:0] got, exp;
    int n_dlv = 0, a_c = -1, ov_c = -1, c;
    for (int k = 0; k < 3; k++) tick(1'b1, 16'h0200 + 16'(k), 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
    n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occupancy: got %0d expected 3", occupancy); end
    tick(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0, acc, dlv, got, exp, under, ov, ir);
    n_cmp++; if (ir !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", ir); end
    sb.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occupancy: got %0d expected 0", occupancy); end
    for (int t = 0; t < 12 && n_dlv < 1; t++) begin
      c = cyc;
      tick(t == 0, 16'h1234, 1'b1, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
      if (acc) a_c = c;
      if (ov && ov_c < 0) ov_c = c;
      if (dlv) begin
        n_dlv++;
        n_cmp++; if (under || got !== exp || got !== 16'h1234) begin n_fail++; $display("FAIL flush_after_data: got %h expected 1234", got); end
      end
    end
    n_cmp++; if (a_c < 0 || ov_c - a_c != 4) begin n_fail++; $display("FAIL flush_after_latency: got %0d expected 4", ov_c - a_c); end
  endtask

  task automatic test_reset_mid();
    logic acc, dlv, under, ov, ir; logic [W-1:0] got, exp;
    for (int k = 0; k < 4; k++) tick(1'b1, 16'h0300 + 16'(k), 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
    n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL rstmid_pre_occupancy: got %0d expected 4", occupancy); end
    tick(1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, acc, dlv, got, exp, under, ov, ir);
    sb.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rstmid_out_data: got %h expected 0000", out_data); end
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rstmid_occupancy: got %0d expected 0", occupancy); end
    flush = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
  endtask

  task automatic test_random();
    logic acc, dlv, under, ov, ir, iv, ordy, ir_probe; logic [W-1:0] got, exp;
    int n_sent = 0, n_dlv = 0;
    for (int t = 0; t < 20000 && n_sent < 1000; t++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 6);
      out_ready = ~ordy; #1; ir_probe = in_ready;
      tick(iv, 16'($urandom), ordy, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
`ifdef PIPE_REGISTER_SKID_EN
      n_cmp++; if (ir_probe !== ir) begin n_fail++; $display("FAIL rand_ready_comb: got %b then %b expected stable", ir_probe, ir); end
`endif
      if (acc) n_sent++;
      if (dlv) begin
        n_dlv++;
        n_cmp++; if (under || got !== exp) begin n_fail++; $display("FAIL rand_data: got %h expected %h (underflow=%0b)", got, exp, under); end
      end
      n_cmp++; if (int'(occupancy) != sb.size() || int'(occupancy) > MAXOCC) begin n_fail++; $display("FAIL rand_occupancy: got %0d expected %0d", occupancy, sb.size()); end
    end
    for (int t = 0; t < 50 && sb.size() > 0; t++) begin
      tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, acc, dlv, got, exp, under, ov, ir);
      if (dlv) begin
        n_dlv++;
        n_cmp++; if (under || got !== exp) begin n_fail++; $display("FAIL rand_drain_data: got %h expected %h", got, exp); end
      end
    end
    n_cmp++; if (n_sent != 1000 || n_dlv != 1000) begin n_fail++; $display("FAIL rand_count: got sent %0d delivered %0d expected 1000/1000", n_sent, n_dlv); end
  endtask

  initial begin
    in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_register.md
PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 SHALL have parameter FIXED_POINT, default 16: data word width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, FIXED_POINT bits: upstream data word.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port out_data, output, FIXED_POINT bits: last-stage data word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-011 SHALL have port flush, input, 1 bit: discard all held words.
REQ-012 SHALL have port occupancy, output, $clog2(DEPTH+2) bits: number of valid words held.

Function
REQ-013 SHALL transfer a word on an edge where in_valid=1 and in_ready=1 (accept), and where out_valid=1 and out_ready=1 (deliver).
REQ-014 SHALL implement a chain of DEPTH stages, each holding a data word and a valid bit; out_data/out_valid SHALL be driven directly from the last stage's registers.
REQ-015 SHALL advance stage i into stage i+1 when stage i+1 is empty or is itself advancing or delivering in the same cycle.
REQ-016 SHALL hold a valid stage's word unchanged while it cannot advance; no word SHALL be lost, duplicated or reordered.
REQ-017 SHALL collapse bubbles: an empty stage SHALL be filled by the word behind it even while downstream stages are stalled.
REQ-018 SHALL give latency DEPTH cycles, accept edge to first cycle out_valid=1, when no stalls occur; throughput SHALL be one word per cycle.
REQ-019 SHALL leave the data bits of empty stages don't-care to consumers; out_data is meaningful only while out_valid=1.
REQ-020 SHALL drive in_ready=1 when stage 0 is empty or advancing, except REQ-022 and REQ-029.
REQ-021 SHALL update occupancy every cycle as the previous value plus accepts minus deliveries, equal to the count of valid bits held; accept and deliver in the same cycle SHALL leave it unchanged.
REQ-022 SHALL, when flush=1, drive in_ready=0, ignore in_valid, and clear every valid bit at that edge; occupancy SHALL read 0 and out_valid 0 from the next cycle.
REQ-023 SHALL count a deliver in the flush cycle as a normal transfer; no other held word SHALL emerge after a flush.

Reset
REQ-024 SHALL, on an edge with rst=1, clear all valid bits and all stage data to 0, so that out_valid=0, out_data=0, occupancy=0 and in_ready=1 in the following cycle.
REQ-025 SHALL give rst priority over flush, in_valid and out_ready, including mid-stream with any occupancy.

Configuration
REQ-026 SHALL use macro PIPE_REGISTER_SKID_EN to include or exclude an input skid buffer.
REQ-027 SHALL, with PIPE_REGISTER_SKID_EN undefined, drive in_ready combinationally through the stage chain from out_ready; maximum occupancy SHALL be DEPTH.
REQ-028 SHALL, with PIPE_REGISTER_SKID_EN defined, add one skid entry ahead of stage 0 and make in_ready a registered signal with no combinational path from out_ready.
REQ-029 SHALL, with skid enabled, deassert in_ready while the skid entry is occupied; maximum occupancy SHALL be DEPTH+1; flush and rst SHALL also clear the skid entry; REQ-018 latency SHALL be unchanged when the skid entry is empty.

Verification (FIXED_POINT=16, DEPTH=4)
REQ-030 SHALL cover streaming: accept 0x0001..0x0008 back-to-back with out_ready=1 -> first out_valid 4 cycles after the first accept, then 0x0001..0x0008 delivered in 8 consecutive cycles.
REQ-031 SHALL cover backpressure: out_ready=0 for 8 cycles with in_valid=1 -> occupancy stops at 4 (5 with skid), in_ready=0, no loss; on release, order is preserved.
REQ-032 SHALL cover bubble collapse: 0x00AA, a 2-cycle gap, then 0x00BB with out_ready=0 -> occupancy=2 and both words packed in the last two stages; 0x00AA is delivered first.
REQ-033 SHALL cover flush: flush=1 for one cycle at occupancy 3 -> out_valid=0 and occupancy=0 next cycle; a subsequent 0x1234 emerges after 4 cycles.
REQ-034 SHALL cover reset mid-stream: rst=1 for one cycle at occupancy 4 -> out_valid=0, out_data=0x0000, occupancy=0 and in_ready=1 next cycle.
REQ-035 SHALL cover skid build: random out_ready -> in_ready changes only on clock edges, with no loss or duplication over 1000 words.
